// File: rtl/fast_serial_tx.sv
// fast_serial_tx
//   Avalon-ST byte sink that serialises each byte onto the FT2232H fast
//   opto-isolated serial link. Frame on fsdi: start(0), D0..D7 LSB first,
//   source bit (CHANNEL_BIT), then at least one idle bit (1).
//
// Parameters
//   CLK_DIV      clk_clk cycles per fsclk half-period (>=1)
//   CHANNEL_BIT  value sent in the source bit (0 = FTDI channel A)
//
// Ports
//   clk_clk      in   system clock
//   reset_reset  in   synchronous active-high reset
//   in_ready     out  Avalon-ST ready
//   in_valid     in   Avalon-ST valid
//   in_data      in   Avalon-ST byte
//   fsclk        out  serial clock to the FTDI (sampled by it on rising edge)
//   fsdi         out  serial data to the FTDI, idle high
//   fscts        in   FTDI clear-to-send, asynchronous, high = ready
//   tx_busy      out  high while a frame (including its idle bit) is in progress
//   frames_sent  out  count of completed frames, wraps
module fast_serial_tx #(
    parameter int unsigned CLK_DIV     = 1,
    parameter bit          CHANNEL_BIT = 1'b0
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    output logic        in_ready,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        fsclk,
    output logic        fsdi,
    input  logic        fscts,
    output logic        tx_busy,
    output logic [15:0] frames_sent
);

    localparam int unsigned      DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_SRC,
        ST_GAP
    } state_t;

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             fsclk_q, fsclk_d;
    logic             cts_meta_q, cts_meta_d;
    logic             cts_s_q, cts_s_d;
    logic             rdy_r_q, rdy_r_d;
    logic [7:0]       hold_q, hold_d;
    logic             hold_valid_q, hold_valid_d;
    state_t           state_q, state_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [3:0]       bitcnt_q, bitcnt_d;
    logic             fsdi_q, fsdi_d;
    logic [15:0]      frames_sent_q, frames_sent_d;

    logic div_last;
    logic fall_tick;
    logic load;
    logic accept;

    assign in_ready    = rdy_r_q & ~hold_valid_q;
    assign fsclk       = fsclk_q;
    assign fsdi        = fsdi_q;
    assign tx_busy     = (state_q != ST_IDLE);
    assign frames_sent = frames_sent_q;

    always_comb begin
        div_cnt_d     = div_cnt_q;
        fsclk_d       = fsclk_q;
        cts_meta_d    = fscts;
        cts_s_d       = cts_meta_q;
        rdy_r_d       = 1'b1;
        hold_d        = hold_q;
        hold_valid_d  = hold_valid_q;
        state_d       = state_q;
        shreg_d       = shreg_q;
        bitcnt_d      = bitcnt_q;
        fsdi_d        = fsdi_q;
        frames_sent_d = frames_sent_q;
        load          = 1'b0;

        // Free-running divider; fsclk toggles at terminal count.
        div_last  = (div_cnt_q == DIV_LAST);
        fall_tick = div_last & fsclk_q;
        if (div_last) begin
            div_cnt_d = '0;
            fsclk_d   = ~fsclk_q;
        end else begin
            div_cnt_d = div_cnt_q + 1'b1;
        end

        // fsdi only changes as fsclk falls, so it is stable for a full
        // half-period before the FTDI samples it on the rising edge.
        if (fall_tick) begin
            unique case (state_q)
                ST_IDLE: begin
                    fsdi_d = 1'b1;
                    if (hold_valid_q && cts_s_q) begin
                        shreg_d = hold_q;
                        load    = 1'b1;
                        fsdi_d  = 1'b0;
                        state_d = ST_START;
                    end
                end
                ST_START: begin
                    fsdi_d   = shreg_q[0];
                    shreg_d  = {1'b0, shreg_q[7:1]};
                    bitcnt_d = 4'd1;
                    state_d  = ST_DATA;
                end
                ST_DATA: begin
                    if (bitcnt_q == 4'd8) begin
                        fsdi_d  = CHANNEL_BIT;
                        state_d = ST_SRC;
                    end else begin
                        fsdi_d   = shreg_q[0];
                        shreg_d  = {1'b0, shreg_q[7:1]};
                        bitcnt_d = bitcnt_q + 4'd1;
                    end
                end
                ST_SRC: begin
                    fsdi_d  = 1'b1;
                    state_d = ST_GAP;
                end
                ST_GAP: begin
                    frames_sent_d = frames_sent_q + 16'd1;
                    state_d       = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // A load drains the hold register; an accept in the same cycle
        // refills it, so the accept is applied last.
        accept = in_valid & in_ready;
        if (load) begin
            hold_valid_d = 1'b0;
        end
        if (accept) begin
            hold_d       = in_data;
            hold_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            div_cnt_q     <= '0;
            fsclk_q       <= 1'b1;
            cts_meta_q    <= 1'b0;
            cts_s_q       <= 1'b0;
            rdy_r_q       <= 1'b0;
            hold_q        <= '0;
            hold_valid_q  <= 1'b0;
            state_q       <= ST_IDLE;
            shreg_q       <= '0;
            bitcnt_q      <= '0;
            fsdi_q        <= 1'b1;
            frames_sent_q <= '0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            fsclk_q       <= fsclk_d;
            cts_meta_q    <= cts_meta_d;
            cts_s_q       <= cts_s_d;
            rdy_r_q       <= rdy_r_d;
            hold_q        <= hold_d;
            hold_valid_q  <= hold_valid_d;
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            bitcnt_q      <= bitcnt_d;
            fsdi_q        <= fsdi_d;
            frames_sent_q <= frames_sent_d;
        end
    end

endmodule

// File: tb/tb_fast_serial_tx.sv
// Bench for fast_serial_tx: bytes are pushed to an expected queue when
// accepted; a link monitor decodes fsdi on fsclk rising edges into a
// received queue, and each test pops and compares.
module tb_fast_serial_tx;

    localparam int unsigned CLK_DIV = 2;
    localparam bit          CHB     = 1'b0;
    localparam int unsigned BIT_CLK = 2 * CLK_DIV;

    logic        clk_clk;
    logic        reset_reset;
    logic        in_ready;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        fsclk;
    logic        fsdi;
    logic        fscts;
    logic        tx_busy;
    logic [15:0] frames_sent;

    fast_serial_tx #(
        .CLK_DIV     (CLK_DIV),
        .CHANNEL_BIT (CHB)
    ) dut (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .in_ready    (in_ready),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .fsclk       (fsclk),
        .fsdi        (fsdi),
        .fscts       (fscts),
        .tx_busy     (tx_busy),
        .frames_sent (frames_sent)
    );

    initial clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned exp_frames = 0;

    logic [7:0] exp_q[$];
    logic [9:0] rx_q[$];

    // Link monitor, sampled 1 time unit after each rising clk edge.
    int unsigned cyc = 0;
    int unsigned mon_bits = 0;
    logic [9:0]  fr = '0;
    bit fsclk_prev = 1'b1, fsdi_prev = 1'b1, busy_prev = 1'b0;
    bit have_rise = 1'b0, have_end = 1'b0;
    int unsigned last_rise = 0, busy_start = 0, busy_end = 0;
    int unsigned busy_len = 0, gap_len = 0, start_cyc = 0;
    int unsigned glitch_cnt = 0, per_err = 0;

    always begin
        @(posedge clk_clk);
        cyc++;
        #1;
        if (reset_reset) begin
            mon_bits   = 0;
            fsclk_prev = 1'b1;
            fsdi_prev  = 1'b1;
            busy_prev  = 1'b0;
            have_rise  = 1'b0;
            have_end   = 1'b0;
        end else begin
            if (fsdi !== fsdi_prev && !(fsclk_prev && !fsclk)) glitch_cnt++;
            if (fsdi_prev && !fsdi && mon_bits == 0) start_cyc = cyc;
            if (fsclk && !fsclk_prev) begin
                if (have_rise && (cyc - last_rise) != BIT_CLK) per_err++;
                have_rise = 1'b1;
                last_rise = cyc;
                if (mon_bits == 0) begin
                    if (fsdi == 1'b0) mon_bits = 1;
                end else begin
                    fr[mon_bits-1] = fsdi;
                    if (mon_bits == 10) begin
                        rx_q.push_back(fr);
                        mon_bits = 0;
                    end else begin
                        mon_bits++;
                    end
                end
            end
            if (tx_busy && !busy_prev) begin
                busy_start = cyc;
                if (have_end) gap_len = cyc - busy_end;
            end
            if (!tx_busy && busy_prev) begin
                busy_len = cyc - busy_start;
                busy_end = cyc;
                have_end = 1'b1;
            end
            fsclk_prev = fsclk;
            fsdi_prev  = fsdi;
            busy_prev  = tx_busy;
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge
    // with in_valid still asserted.
    task automatic send_byte(input logic [7:0] b, output bit ok);
        int unsigned n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 400) begin
            @(negedge clk_clk);
            n++;
        end
        ok = in_ready;
        if (ok) begin
            @(posedge clk_clk);
            exp_q.push_back(b);
            @(negedge clk_clk);
        end
    endtask

    task automatic wait_rx(output bit ok);
        int unsigned n = 0;
        while (rx_q.size() == 0 && n < 2000) begin
            @(negedge clk_clk);
            n++;
        end
        ok = (rx_q.size() != 0);
    endtask

    task automatic wait_idle(output bit ok);
        int unsigned n = 0;
        while (tx_busy && n < 2000) begin
            @(negedge clk_clk);
            n++;
        end
        ok = !tx_busy;
    endtask

    task automatic wait_bits(input int unsigned k, output bit ok);
        int unsigned n = 0;
        while (mon_bits != k && n < 2000) begin
            @(negedge clk_clk);
            n++;
        end
        ok = (mon_bits == k);
    endtask

    task automatic test_reset;
        reset_reset = 1'b1;
        in_valid    = 1'b0;
        in_data     = 8'h00;
        fscts       = 1'b1;
        repeat (3) @(negedge clk_clk);
        total++;
        if (fsclk !== 1'b1) begin bad++; $display("FAIL rst_fsclk got=%b want=1", fsclk); end
        total++;
        if (fsdi !== 1'b1) begin bad++; $display("FAIL rst_fsdi got=%b want=1", fsdi); end
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b want=0", in_ready); end
        total++;
        if (tx_busy !== 1'b0) begin bad++; $display("FAIL rst_tx_busy got=%b want=0", tx_busy); end
        total++;
        if (frames_sent !== 16'h0000) begin bad++; $display("FAIL rst_frames got=%h want=0000", frames_sent); end
        reset_reset = 1'b0;
        @(negedge clk_clk);
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_after got=%b want=1", in_ready); end
    endtask

    task automatic test_single;
        bit ok;
        logic [9:0] got, want;
        send_byte(8'hA5, ok);
        in_valid = 1'b0;
        total++;
        if (!ok) begin bad++; $display("FAIL single_accept got=0 want=1"); end
        wait_rx(ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL single_rx timeout");
        end else begin
            got  = rx_q.pop_front();
            want = {1'b1, CHB, exp_q.pop_front()};
            exp_frames++;
            total++;
            if (got !== want) begin bad++; $display("FAIL single_frame got=%b want=%b", got, want); end
        end
        wait_idle(ok);
        total++;
        if (busy_len !== 11 * BIT_CLK) begin bad++; $display("FAIL single_busy_len got=%0d want=%0d", busy_len, 11 * BIT_CLK); end
        total++;
        if (frames_sent !== 16'(exp_frames)) begin bad++; $display("FAIL single_frames got=%h want=%h", frames_sent, 16'(exp_frames)); end
    endtask

    task automatic test_back_to_back;
        bit ok, ok2;
        logic [9:0] got, want;
        send_byte(8'h00, ok);
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_full got=%b want=0", in_ready); end
        send_byte(8'hFF, ok2);
        in_valid = 1'b0;
        total++;
        if (!(ok && ok2)) begin bad++; $display("FAIL b2b_accept got=%b%b want=11", ok, ok2); end
        total++;
        if (tx_busy !== 1'b1) begin bad++; $display("FAIL b2b_accept_in_frame busy got=%b want=1", tx_busy); end
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_full2 got=%b want=0", in_ready); end
        for (int i = 0; i < 2; i++) begin
            wait_rx(ok);
            total++;
            if (!ok) begin
                bad++; $display("FAIL b2b_rx%0d timeout", i);
            end else begin
                got  = rx_q.pop_front();
                want = {1'b1, CHB, exp_q.pop_front()};
                exp_frames++;
                total++;
                if (got !== want) begin bad++; $display("FAIL b2b_frame%0d got=%b want=%b", i, got, want); end
            end
        end
        wait_idle(ok);
        total++;
        if (gap_len !== BIT_CLK) begin bad++; $display("FAIL b2b_gap got=%0d want=%0d", gap_len, BIT_CLK); end
        total++;
        if (busy_len !== 11 * BIT_CLK) begin bad++; $display("FAIL b2b_busy_len got=%0d want=%0d", busy_len, 11 * BIT_CLK); end
        total++;
        if (frames_sent !== 16'(exp_frames)) begin bad++; $display("FAIL b2b_frames got=%h want=%h", frames_sent, 16'(exp_frames)); end
    endtask

    task automatic test_cts_block;
        bit ok;
        int unsigned viol = 0;
        int unsigned c0;
        logic [9:0] got, want;
        fscts = 1'b0;
        repeat (4) @(negedge clk_clk);
        send_byte(8'h3C, ok);
        in_valid = 1'b0;
        total++;
        if (!ok) begin bad++; $display("FAIL cts_accept got=0 want=1"); end
        repeat (40) begin
            @(negedge clk_clk);
            if (fsdi !== 1'b1 || tx_busy !== 1'b0) viol++;
        end
        total++;
        if (viol != 0) begin bad++; $display("FAIL cts_hold_idle violations got=%0d want=0", viol); end
        fscts = 1'b1;
        c0    = cyc;
        wait_rx(ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL cts_rx timeout");
        end else begin
            got  = rx_q.pop_front();
            want = {1'b1, CHB, exp_q.pop_front()};
            exp_frames++;
            total++;
            if (got !== want) begin bad++; $display("FAIL cts_frame got=%b want=%b", got, want); end
        end
        // Two synchroniser edges, then the first falling fsclk edge after that.
        total++;
        if (start_cyc < c0 + 3 || start_cyc >= c0 + 3 + BIT_CLK) begin
            bad++; $display("FAIL cts_start_delay got=%0d want=[%0d,%0d)", start_cyc - c0, 3, 3 + BIT_CLK);
        end
        wait_idle(ok);
    endtask

    task automatic test_cts_mid;
        bit ok, ok2;
        int unsigned viol = 0;
        logic [9:0] got, want;
        send_byte(8'h81, ok);
        send_byte(8'h42, ok2);
        in_valid = 1'b0;
        total++;
        if (!(ok && ok2)) begin bad++; $display("FAIL mid_accept got=%b%b want=11", ok, ok2); end
        wait_bits(5, ok);
        fscts = 1'b0;
        wait_rx(ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL mid_rx1 timeout");
        end else begin
            got  = rx_q.pop_front();
            want = {1'b1, CHB, exp_q.pop_front()};
            exp_frames++;
            total++;
            if (got !== want) begin bad++; $display("FAIL mid_frame1 got=%b want=%b", got, want); end
        end
        wait_idle(ok);
        repeat (40) begin
            @(negedge clk_clk);
            if (fsdi !== 1'b1 || tx_busy !== 1'b0) viol++;
        end
        total++;
        if (viol != 0) begin bad++; $display("FAIL mid_wait_cts violations got=%0d want=0", viol); end
        fscts = 1'b1;
        wait_rx(ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL mid_rx2 timeout");
        end else begin
            got  = rx_q.pop_front();
            want = {1'b1, CHB, exp_q.pop_front()};
            exp_frames++;
            total++;
            if (got !== want) begin bad++; $display("FAIL mid_frame2 got=%b want=%b", got, want); end
        end
        wait_idle(ok);
        total++;
        if (frames_sent !== 16'(exp_frames)) begin bad++; $display("FAIL mid_frames got=%h want=%h", frames_sent, 16'(exp_frames)); end
    endtask

    task automatic test_reset_mid;
        bit ok, ok2;
        int unsigned viol = 0;
        logic [9:0] got, want;
        send_byte(8'hC3, ok);
        send_byte(8'h99, ok2);
        in_valid = 1'b0;
        wait_bits(7, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL rmid_reach_d5 timeout"); end
        reset_reset = 1'b1;
        @(negedge clk_clk);
        total++;
        if (fsdi !== 1'b1) begin bad++; $display("FAIL rmid_fsdi got=%b want=1", fsdi); end
        total++;
        if (fsclk !== 1'b1) begin bad++; $display("FAIL rmid_fsclk got=%b want=1", fsclk); end
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL rmid_in_ready got=%b want=0", in_ready); end
        total++;
        if (frames_sent !== 16'h0000) begin bad++; $display("FAIL rmid_frames got=%h want=0000", frames_sent); end
        exp_q.delete();
        exp_frames  = 0;
        reset_reset = 1'b0;
        repeat (40) begin
            @(negedge clk_clk);
            if (tx_busy !== 1'b0) viol++;
        end
        total++;
        if (viol != 0 || rx_q.size() != 0) begin
            bad++; $display("FAIL rmid_discard busy_cycles=%0d rx=%0d want=0,0", viol, rx_q.size());
        end
        rx_q.delete();
        send_byte(8'h5A, ok);
        in_valid = 1'b0;
        wait_rx(ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL rmid_rx timeout");
        end else begin
            got  = rx_q.pop_front();
            want = {1'b1, CHB, exp_q.pop_front()};
            exp_frames++;
            total++;
            if (got !== want) begin bad++; $display("FAIL rmid_frame got=%b want=%b", got, want); end
        end
        wait_idle(ok);
        total++;
        if (frames_sent !== 16'(exp_frames)) begin bad++; $display("FAIL rmid_frames_after got=%h want=%h", frames_sent, 16'(exp_frames)); end
    endtask

    // Preloads the counter rather than sending 65535 frames.
    task automatic test_wrap;
        bit ok;
        logic [9:0] got, want;
        @(negedge clk_clk);
        force dut.frames_sent_q = 16'hFFFF;
        @(negedge clk_clk);
        release dut.frames_sent_q;
        @(negedge clk_clk);
        total++;
        if (frames_sent !== 16'hFFFF) begin bad++; $display("FAIL wrap_preload got=%h want=ffff", frames_sent); end
        send_byte(8'h11, ok);
        in_valid = 1'b0;
        wait_rx(ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL wrap_rx timeout");
        end else begin
            got  = rx_q.pop_front();
            want = {1'b1, CHB, exp_q.pop_front()};
            total++;
            if (got !== want) begin bad++; $display("FAIL wrap_frame got=%b want=%b", got, want); end
        end
        wait_idle(ok);
        total++;
        if (frames_sent !== 16'h0000) begin bad++; $display("FAIL wrap_count got=%h want=0000", frames_sent); end
    endtask

    task automatic test_link_timing;
        total++;
        if (glitch_cnt != 0) begin bad++; $display("FAIL link_fsdi_off_fall got=%0d want=0", glitch_cnt); end
        total++;
        if (per_err != 0) begin bad++; $display("FAIL link_fsclk_period got=%0d want=0", per_err); end
    endtask

    initial begin
        reset_reset = 1'b1;
        in_valid    = 1'b0;
        in_data     = 8'h00;
        fscts       = 1'b0;
        test_reset;
        test_single;
        test_back_to_back;
        test_cts_block;
        test_cts_mid;
        test_reset_mid;
        test_wrap;
        test_link_timing;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
